// File: rtl/fir_mac_scheduler_if.sv
// fir_mac_scheduler_if
//   Bundles the sample stream, coefficient write port, shared-multiplier
//   operand/product lines, output stream and busy flag of the decimating
//   FIR MAC scheduler.
//   slave  : view taken by fir_mac_scheduler
//   master : view taken by the surrounding logic (source, sink, multiplier)
// Signals
//   s_data/s_valid/s_ready        input sample stream (signed)
//   coef_we/coef_addr/coef_data   coefficient register write port
//   mul_din0/mul_din1/mul_dout    shared multiplier operands and product
//   m_data/m_valid/m_ready        filter output stream (signed)
//   busy                          scheduler is in a MAC run or holding output
interface fir_mac_scheduler_if #(
  parameter int NTAPS  = 16,
  parameter int DATA_W = 16,
  parameter int COEF_W = 10,
  parameter int PROD_W = 26,
  parameter int ACC_W  = 30
);
  localparam int ADDR_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  logic signed [DATA_W-1:0] s_data;
  logic                     s_valid;
  logic                     s_ready;
  logic                     coef_we;
  logic [ADDR_W-1:0]        coef_addr;
  logic [COEF_W-1:0]        coef_data;
  logic signed [DATA_W-1:0] mul_din0;
  logic [COEF_W-1:0]        mul_din1;
  logic signed [PROD_W-1:0] mul_dout;
  logic signed [ACC_W-1:0]  m_data;
  logic                     m_valid;
  logic                     m_ready;
  logic                     busy;

  modport slave (
    input  s_data, s_valid, coef_we, coef_addr, coef_data, mul_dout, m_ready,
    output s_ready, mul_din0, mul_din1, m_data, m_valid, busy
  );

  modport master (
    output s_data, s_valid, coef_we, coef_addr, coef_data, mul_dout, m_ready,
    input  s_ready, mul_din0, mul_din1, m_data, m_valid, busy
  );
endinterface

// File: rtl/fir_mac_scheduler.sv
// fir_mac_scheduler
//   Decimating FIR stage that time-shares one external combinational
//   multiplier across all taps. Samples go into a circular delay line; every
//   DECIM accepted samples the scheduler runs NTAPS MAC cycles and emits one
//   accumulated output.
// Ports
//   ap_clk  clock, rising edge
//   ap_rst  synchronous reset, active high
//   bus     fir_mac_scheduler_if.slave (streams, coef port, multiplier lines)
//
// state  | meaning
// S_IDLE | accepting samples and coefficient writes
// S_MAC  | one tap per cycle through the shared multiplier
// S_OUT  | holding the finished sum until downstream takes it
module fir_mac_scheduler #(
  parameter int NTAPS  = 16,
  parameter int DECIM  = 2,
  parameter int DATA_W = 16,
  parameter int COEF_W = 10,
  parameter int PROD_W = 26,
  parameter int ACC_W  = 30
) (
  input logic                 ap_clk,
  input logic                 ap_rst,
  fir_mac_scheduler_if.slave  bus
);
  localparam int ADDR_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NTAPS - 1);
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(DECIM - 1);
  localparam logic [ADDR_W:0]   NTAPS_L  = (ADDR_W + 1)'(NTAPS);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                   r_state, w_state_nxt;
  logic signed [DATA_W-1:0] r_buf  [NTAPS];
  logic [COEF_W-1:0]        r_coef [NTAPS];
  logic [ADDR_W-1:0]        r_wr_ptr, r_rd_ptr, r_tap;
  logic [PH_W-1:0]          r_phase;
  logic signed [ACC_W-1:0]  r_acc, r_m_data;
  logic signed [DATA_W-1:0] r_din0;
  logic [COEF_W-1:0]        r_din1;

  logic                     w_s_ready, w_m_valid, w_busy;
  logic                     w_accept, w_trigger, w_mac_last, w_coef_wr;
  logic [COEF_W-1:0]        w_coef0;
  logic signed [ACC_W-1:0]  w_acc_sum;

  function automatic logic [ADDR_W-1:0] f_inc(input logic [ADDR_W-1:0] p);
    return (p == LAST_TAP) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [ADDR_W-1:0] f_dec(input logic [ADDR_W-1:0] p);
    return (p == '0) ? LAST_TAP : p - 1'b1;
  endfunction

  assign w_accept   = (r_state == S_IDLE) && bus.s_valid && !ap_rst;
  assign w_trigger  = w_accept && (r_phase == PH_LAST);
  assign w_mac_last = (r_tap == LAST_TAP);
  assign w_coef_wr  = bus.coef_we && (r_state == S_IDLE) &&
                      ({1'b0, bus.coef_addr} < NTAPS_L);
  // A tap-0 write in the triggering cycle is forwarded so the whole run
  // sees one consistent coefficient set.
  assign w_coef0    = (w_coef_wr && bus.coef_addr == '0) ? bus.coef_data : r_coef[0];
  assign w_acc_sum  = r_acc + ACC_W'($signed(bus.mul_dout));

  always_ff @(posedge ap_clk) begin
    if (ap_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_m_valid   = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_s_ready = !ap_rst;
        if (w_trigger) w_state_nxt = S_MAC;
      end
      S_MAC: begin
        w_busy = 1'b1;
        if (w_mac_last) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        w_busy    = 1'b1;
        w_m_valid = 1'b1;
        if (bus.m_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_buf[i]  <= '0;
        r_coef[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_tap    <= '0;
      r_phase  <= '0;
      r_acc    <= '0;
      r_m_data <= '0;
      r_din0   <= '0;
      r_din1   <= '0;
    end else begin
      if (w_coef_wr) r_coef[bus.coef_addr] <= bus.coef_data;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_buf[r_wr_ptr] <= bus.s_data;
            r_wr_ptr        <= f_inc(r_wr_ptr);
            if (w_trigger) begin
              r_phase  <= '0;
              r_acc    <= '0;
              r_tap    <= '0;
              // Tap 0 is the sample arriving now; tap 1 sits one slot behind it.
              r_rd_ptr <= f_dec(r_wr_ptr);
              r_din0   <= bus.s_data;
              r_din1   <= w_coef0;
            end else begin
              r_phase <= r_phase + 1'b1;
            end
          end
        end
        S_MAC: begin
          r_acc <= w_acc_sum;
          if (w_mac_last) begin
            r_m_data <= w_acc_sum;
            r_din0   <= '0;
            r_din1   <= '0;
          end else begin
            r_tap    <= r_tap + 1'b1;
            r_rd_ptr <= f_dec(r_rd_ptr);
            r_din0   <= r_buf[r_rd_ptr];
            r_din1   <= r_coef[r_tap + 1'b1];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s_ready  = w_s_ready;
  assign bus.m_valid  = w_m_valid;
  assign bus.busy     = w_busy;
  assign bus.m_data   = r_m_data;
  assign bus.mul_din0 = r_din0;
  assign bus.mul_din1 = r_din1;
endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler: one DECIM=1 instance (dut1) and one
// DECIM=2 instance (dut2), each with a behavioural 16s x 10u multiplier.
module tb_fir_mac_scheduler;
  localparam int NTAPS  = 16;
  localparam int DATA_W = 16;
  localparam int COEF_W = 10;
  localparam int PROD_W = 26;
  localparam int ACC_W  = 30;
  localparam int ADDR_W = 4;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 ap_clk = ~ap_clk;

  fir_mac_scheduler_if #(.NTAPS(NTAPS), .DATA_W(DATA_W), .COEF_W(COEF_W),
                         .PROD_W(PROD_W), .ACC_W(ACC_W)) bus1 ();
  fir_mac_scheduler_if #(.NTAPS(NTAPS), .DATA_W(DATA_W), .COEF_W(COEF_W),
                         .PROD_W(PROD_W), .ACC_W(ACC_W)) bus2 ();

  logic signed [PROD_W:0] prod1, prod2;
  assign prod1 = $signed(bus1.mul_din0) * $signed({1'b0, bus1.mul_din1});
  assign prod2 = $signed(bus2.mul_din0) * $signed({1'b0, bus2.mul_din1});
  assign bus1.mul_dout = prod1[PROD_W-1:0];
  assign bus2.mul_dout = prod2[PROD_W-1:0];

  fir_mac_scheduler #(.NTAPS(NTAPS), .DECIM(1), .DATA_W(DATA_W), .COEF_W(COEF_W),
                      .PROD_W(PROD_W), .ACC_W(ACC_W))
    u_dut1 (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus1));

  fir_mac_scheduler #(.NTAPS(NTAPS), .DECIM(2), .DATA_W(DATA_W), .COEF_W(COEF_W),
                      .PROD_W(PROD_W), .ACC_W(ACC_W))
    u_dut2 (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus2));

  task automatic wr_coef(input int d, input int a, input int v);
    @(negedge ap_clk);
    if (d == 1) begin
      bus1.coef_we = 1'b1; bus1.coef_addr = ADDR_W'(a); bus1.coef_data = COEF_W'(v);
    end else begin
      bus2.coef_we = 1'b1; bus2.coef_addr = ADDR_W'(a); bus2.coef_data = COEF_W'(v);
    end
    @(negedge ap_clk);
    bus1.coef_we = 1'b0;
    bus2.coef_we = 1'b0;
  endtask

  // Returns on the falling edge right after the accepting rising edge.
  task automatic push(input int d, input int v, output bit ok);
    ok = 1'b0;
    @(negedge ap_clk);
    if (d == 1) begin bus1.s_valid = 1'b1; bus1.s_data = DATA_W'(v); end
    else        begin bus2.s_valid = 1'b1; bus2.s_data = DATA_W'(v); end
    for (int n = 0; n < 200 && !ok; n++) begin
      if ((d == 1) ? bus1.s_ready : bus2.s_ready) ok = 1'b1;
      @(negedge ap_clk);
    end
    bus1.s_valid = 1'b0;
    bus2.s_valid = 1'b0;
  endtask

  task automatic get_out(input int d, output logic signed [ACC_W-1:0] data, output bit ok);
    ok   = 1'b0;
    data = '0;
    for (int n = 0; n < 100 && !ok; n++) begin
      if ((d == 1) ? bus1.m_valid : bus2.m_valid) begin
        ok   = 1'b1;
        data = (d == 1) ? bus1.m_data : bus2.m_data;
      end
      @(negedge ap_clk);
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    repeat (2) @(negedge ap_clk);
    checks++;
    if (bus1.s_ready !== 1'b0 || bus2.s_ready !== 1'b0) begin
      failures++; $display("FAIL reset_s_ready got=%b/%b want=0", bus1.s_ready, bus2.s_ready);
    end
    checks++;
    if (bus1.m_valid !== 1'b0 || bus1.busy !== 1'b0 || bus1.m_data !== '0) begin
      failures++; $display("FAIL reset_outputs m_valid=%b busy=%b m_data=%0d want 0/0/0",
                           bus1.m_valid, bus1.busy, bus1.m_data);
    end
    checks++;
    if (bus1.mul_din0 !== '0 || bus1.mul_din1 !== '0) begin
      failures++; $display("FAIL reset_operands din0=%0d din1=%0d want 0/0",
                           bus1.mul_din0, bus1.mul_din1);
    end
    ap_rst = 1'b0;
    #1;
    checks++;
    if (bus1.s_ready !== 1'b1 || bus2.s_ready !== 1'b1) begin
      failures++; $display("FAIL post_reset_s_ready got=%b/%b want=1", bus1.s_ready, bus2.s_ready);
    end
  endtask

  task automatic test_impulse();
    bit ok;
    logic signed [ACC_W-1:0] got, exp;
    for (int k = 0; k < NTAPS; k++) wr_coef(1, k, k + 1);
    for (int j = 0; j <= NTAPS; j++) begin
      push(1, (j == 0) ? 1 : 0, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL impulse_accept sample=%0d s_ready stayed 0", j); end
      if (j == 0) begin
        for (int k = 0; k < NTAPS; k++) begin
          checks++;
          if (bus1.mul_din1 !== COEF_W'(k + 1) || bus1.busy !== 1'b1) begin
            failures++; $display("FAIL impulse_din1 tap=%0d got=%0d busy=%b want=%0d busy=1",
                                 k, bus1.mul_din1, bus1.busy, k + 1);
          end
          @(negedge ap_clk);
        end
      end
      get_out(1, got, ok);
      exp = (j < NTAPS) ? ACC_W'(j + 1) : '0;
      checks++;
      if (!ok || got !== exp) begin
        failures++; $display("FAIL impulse_out sample=%0d got=%0d valid_seen=%b want=%0d", j, got, ok, exp);
      end
    end
  endtask

  task automatic test_full_scale();
    bit ok;
    logic signed [ACC_W-1:0] got, exp;
    for (int k = 0; k < NTAPS; k++) wr_coef(1, k, 1023);
    for (int j = 0; j < NTAPS; j++) begin
      push(1, -32768, ok);
      get_out(1, got, ok);
      exp = ACC_W'(-(j + 1) * 33521664);
      checks++;
      if (!ok || got !== exp) begin
        failures++; $display("FAIL full_scale sample=%0d got=%0d want=%0d", j, got, exp);
      end
    end
  endtask

  task automatic test_decim2();
    bit ok;
    logic signed [ACC_W-1:0] got, exp;
    for (int k = 0; k < NTAPS; k++) wr_coef(2, k, 1);
    for (int m = 1; m <= 9; m++) begin
      push(2, 100, ok);
      @(negedge ap_clk);
      checks++;
      if (bus2.m_valid !== 1'b0 || bus2.busy !== 1'b0) begin
        failures++; $display("FAIL decim2_odd m=%0d m_valid=%b busy=%b want 0/0", m, bus2.m_valid, bus2.busy);
      end
      push(2, 100, ok);
      get_out(2, got, ok);
      exp = ACC_W'(100 * ((2 * m < NTAPS) ? 2 * m : NTAPS));
      checks++;
      if (!ok || got !== exp) begin
        failures++; $display("FAIL decim2_out m=%0d got=%0d want=%0d", m, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_mac();
    bit ok;
    push(1, 7, ok);
    repeat (7) @(negedge ap_clk);
    checks++;
    if (bus1.busy !== 1'b1) begin failures++; $display("FAIL midmac_busy got=%b want=1", bus1.busy); end
    ap_rst = 1'b1;
    @(negedge ap_clk);
    checks++;
    if (bus1.m_valid !== 1'b0 || bus1.busy !== 1'b0 || bus1.s_ready !== 1'b0) begin
      failures++; $display("FAIL midmac_reset m_valid=%b busy=%b s_ready=%b want 0/0/0",
                           bus1.m_valid, bus1.busy, bus1.s_ready);
    end
    checks++;
    if (bus1.mul_din0 !== '0 || bus1.mul_din1 !== '0 || bus1.m_data !== '0) begin
      failures++; $display("FAIL midmac_regs din0=%0d din1=%0d m_data=%0d want 0",
                           bus1.mul_din0, bus1.mul_din1, bus1.m_data);
    end
    ap_rst = 1'b0;
    test_impulse();
  endtask

  task automatic test_backpressure();
    bit ok;
    logic signed [ACC_W-1:0] got;
    bus1.m_ready = 1'b0;
    push(1, 1, ok);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (bus1.m_valid) ok = 1'b1;
      else @(negedge ap_clk);
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_valid m_valid never rose"); end
    bus1.s_valid = 1'b1;
    bus1.s_data  = DATA_W'(5);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus1.m_valid !== 1'b1 || bus1.m_data !== ACC_W'(1) || bus1.s_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold cycle=%0d m_valid=%b m_data=%0d s_ready=%b want 1/1/0",
                             c, bus1.m_valid, bus1.m_data, bus1.s_ready);
      end
      @(negedge ap_clk);
    end
    bus1.m_ready = 1'b1;
    @(negedge ap_clk);
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      if (bus1.s_ready) ok = 1'b1;
      @(negedge ap_clk);
    end
    bus1.s_valid = 1'b0;
    get_out(1, got, ok);
    checks++;
    if (!ok || got !== ACC_W'(7)) begin
      failures++; $display("FAIL bp_next_sample got=%0d want=7", got);
    end
  endtask

  task automatic test_coef_we_busy();
    bit ok;
    logic signed [ACC_W-1:0] got;
    push(1, 0, ok);
    bus1.coef_we = 1'b1; bus1.coef_addr = '0; bus1.coef_data = COEF_W'(100);
    repeat (3) @(negedge ap_clk);
    bus1.coef_we = 1'b0;
    get_out(1, got, ok);
    checks++;
    if (!ok || got !== ACC_W'(13)) begin failures++; $display("FAIL coef_busy_run got=%0d want=13", got); end
    push(1, 2, ok);
    get_out(1, got, ok);
    checks++;
    if (!ok || got !== ACC_W'(21)) begin failures++; $display("FAIL coef_busy_ignored got=%0d want=21", got); end
    wr_coef(1, 0, 100);
    push(1, 3, ok);
    get_out(1, got, ok);
    checks++;
    if (!ok || got !== ACC_W'(329)) begin failures++; $display("FAIL coef_idle_write got=%0d want=329", got); end
  endtask

  initial begin
    bus1.s_valid = 1'b0; bus1.s_data = '0; bus1.coef_we = 1'b0; bus1.coef_addr = '0;
    bus1.coef_data = '0; bus1.m_ready = 1'b1;
    bus2.s_valid = 1'b0; bus2.s_data = '0; bus2.coef_we = 1'b0; bus2.coef_addr = '0;
    bus2.coef_data = '0; bus2.m_ready = 1'b1;
    test_reset();
    test_impulse();
    test_full_scale();
    test_decim2();
    test_reset_mid_mac();
    test_backpressure();
    test_coef_we_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule
